pattern_fsm: RTL and testbench

Parametrised serial sequence-detector FSM, the generalised successor of the fixed 4-state two-input FSM block. It tracks the longest matched prefix of a compile-time bit pattern on a serial input, and supports an optional overlap mode, a qualifying enable, synchronous clear, and a saturating match counter. It is a leaf block intended for formal and simulation examples, and its state is exported for observation.

---
 rtl/pattern_fsm_pkg.sv | 80 ++++++++
 rtl/pattern_fsm_sat_counter.sv | 43 ++++
 rtl/pattern_fsm.sv | 119 +++++++++++
 tb/tb_pattern_fsm.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/pattern_fsm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pattern_fsm_pkg
// Description : Elaboration-time helpers for the serial pattern detector.
//               delta()       - KMP-style transition: longest prefix of the
//                               pattern that is a suffix of (prefix s, bit b)
//               fail_len()    - longest proper prefix that is also a suffix
//               state_width() - bits needed to hold 0..pat_w
//               Patterns are carried left-aligned in pat_w bits of a 16-bit
//               vector; bit pat_w-1 is the first bit received.
// Revision    : 1.0 - initial release
// ============================================================================
package pattern_fsm_pkg;

  localparam int c_max_pat_w = 16;

  // i-th received bit of the pattern (i = 0 is the first bit on the wire)
  function automatic logic pat_bit(input logic [c_max_pat_w-1:0] pattern,
                                   input int pat_w, input int i);
    return pattern[pat_w-1-i];
  endfunction

  function automatic int state_width(input int pat_w);
    int w;
    w = 1;
    for (int i = 1; i <= 5; i++) begin
      if ((1 << i) < pat_w + 1) w = i + 1;
    end
    return w;
  endfunction

  function automatic int delta(input logic [c_max_pat_w-1:0] pattern,
                               input int pat_w, input int s, input logic b);
    logic [c_max_pat_w:0] t;
    int                   res;
    bit                   ok;
    res = 0;
    t   = '0;
    // t holds the matched prefix followed by the new bit, t[0] oldest
    for (int j = 0; j < c_max_pat_w; j++) begin
      if (j < s) t[j] = pat_bit(pattern, pat_w, j);
    end
    t[s] = b;
    // ascending k with overwrite leaves the longest candidate
    for (int k = 1; k <= c_max_pat_w; k++) begin
      if (k <= s + 1 && k <= pat_w) begin
        ok = 1'b1;
        for (int j = 0; j < c_max_pat_w; j++) begin
          if (j < k) begin
            if (t[s+1-k+j] != pat_bit(pattern, pat_w, j)) ok = 1'b0;
          end
        end
        if (ok) res = k;
      end
    end
    return res;
  endfunction

  function automatic int fail_len(input logic [c_max_pat_w-1:0] pattern,
                                  input int pat_w);
    int res;
    bit ok;
    res = 0;
    for (int k = 1; k < c_max_pat_w; k++) begin
      if (k < pat_w) begin
        ok = 1'b1;
        for (int j = 0; j < c_max_pat_w; j++) begin
          if (j < k) begin
            if (pat_bit(pattern, pat_w, j) != pat_bit(pattern, pat_w, pat_w - k + j))
              ok = 1'b0;
          end
        end
        if (ok) res = k;
      end
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pattern_fsm_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Saturating up-counter with sticky saturation flag.
//               clk, rst_n : clock, asynchronous active-low reset
//               inc        : count request
//               clr        : synchronous clear of count and flag (wins)
//               cnt [W]    : current count, holds at all-ones
//               sat        : set by any inc seen while cnt is all-ones
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic         sat
);

  logic [W-1:0] r_cnt;
  logic         r_sat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_sat <= 1'b0;
    end else if (clr) begin
      r_cnt <= '0;
      r_sat <= 1'b0;
    end else if (inc) begin
      if (r_cnt == {W{1'b1}}) r_sat <= 1'b1;
      else                    r_cnt <= r_cnt + 1'b1;
    end
  end

  assign cnt = r_cnt;
  assign sat = r_sat;

endmodule
`default_nettype wire

// File: rtl/pattern_fsm.sv
`default_nettype none
// ============================================================================
// Module      : pattern_fsm
// Description : Serial sequence detector tracking the longest matched prefix
//               of PATTERN, with optional overlap and saturating match count.
//               clk, rst_n : clock, asynchronous active-low reset
//               en         : sample qualifier for x
//               x          : serial data bit
//               clr        : synchronous clear (state, counter, flags)
//               state      : matched-prefix length, 0..PAT_W-1
//               match      : registered one-cycle pulse per completed match
//               match_cnt  : saturating match count
//               cnt_sat    : sticky, match seen while count was all-ones
// Revision    : 1.0 - initial release
// ============================================================================
module pattern_fsm
  import pattern_fsm_pkg::*;
#(
  parameter int             PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
  parameter int             OVERLAP = 1,
  parameter int             CNT_W   = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic                          x,
  input  logic                          clr,
  output logic [state_width(PAT_W)-1:0] state,
  output logic                          match,
  output logic [CNT_W-1:0]              match_cnt,
  output logic                          cnt_sat
);

  localparam int                   c_sw   = state_width(PAT_W);
  localparam int                   c_ns   = 1 << c_sw;
  localparam logic [c_max_pat_w-1:0] c_pat  = c_max_pat_w'(PATTERN);
  localparam int                   c_fail = fail_len(c_pat, PAT_W);
  localparam logic [c_sw-1:0]      c_full = c_sw'(PAT_W);
  localparam logic [c_sw-1:0]      c_rest = (OVERLAP != 0) ? c_sw'(c_fail) : '0;

  // Constant transition tables, one entry per encodable state; codes at or
  // above PAT_W are unreachable and map to the empty prefix.
  logic [c_sw-1:0] w_dlt0 [c_ns];
  logic [c_sw-1:0] w_dlt1 [c_ns];

  for (genvar s = 0; s < c_ns; s++) begin : g_delta
    if (s < PAT_W) begin : g_live
      localparam int c_d0 = delta(c_pat, PAT_W, s, 1'b0);
      localparam int c_d1 = delta(c_pat, PAT_W, s, 1'b1);
      assign w_dlt0[s] = c_sw'(c_d0);
      assign w_dlt1[s] = c_sw'(c_d1);
    end else begin : g_unreach
      assign w_dlt0[s] = '0;
      assign w_dlt1[s] = '0;
    end
  end

  logic [c_sw-1:0] r_state;
  logic            r_match;
  logic [c_sw-1:0] w_cand;
  logic [c_sw-1:0] w_state_nxt;
  logic            w_hit;
  logic            w_match_nxt;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= '0;
      r_match <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_match <= w_match_nxt;
    end
  end

  // next-state logic
  always_comb begin
    w_cand      = x ? w_dlt1[r_state] : w_dlt0[r_state];
    w_hit       = 1'b0;
    w_state_nxt = r_state;
    if (clr) begin
      w_state_nxt = '0;
    end else if (en) begin
      if (w_cand == c_full) begin
        // full match never becomes a state; fall back to the border
        w_hit       = 1'b1;
        w_state_nxt = c_rest;
      end else begin
        w_state_nxt = w_cand;
      end
    end
  end

  // output logic (registered through r_match)
  always_comb begin
    w_match_nxt = w_hit;
  end

  sat_counter #(
    .W (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_hit),
    .clr   (clr),
    .cnt   (match_cnt),
    .sat   (cnt_sat)
  );

  assign state = r_state;
  assign match = r_match;

  always_ff @(posedge clk) begin
    if (rst_n) assert (r_state < c_full);
  end

endmodule
`default_nettype wire

// File: tb/tb_pattern_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_pattern_fsm
// Description : Scoreboard bench for pattern_fsm. Three instances share the
//               stimulus: a = 1011 overlapping, b = 1011 non-overlapping,
//               c = 11 overlapping with a 2-bit counter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pattern_fsm;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic en    = 1'b0;
  logic x     = 1'b0;
  logic clr   = 1'b0;

  always #5 clk = ~clk;

  logic [2:0] a_state, b_state;
  logic [1:0] c_state;
  logic       a_match, b_match, c_match;
  logic [7:0] a_cnt, b_cnt;
  logic [1:0] c_cnt;
  logic       a_sat, b_sat, c_sat;

  pattern_fsm #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1), .CNT_W(8)) u_a (
    .clk(clk), .rst_n(rst_n), .en(en), .x(x), .clr(clr),
    .state(a_state), .match(a_match), .match_cnt(a_cnt), .cnt_sat(a_sat));

  pattern_fsm #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(0), .CNT_W(8)) u_b (
    .clk(clk), .rst_n(rst_n), .en(en), .x(x), .clr(clr),
    .state(b_state), .match(b_match), .match_cnt(b_cnt), .cnt_sat(b_sat));

  pattern_fsm #(.PAT_W(2), .PATTERN(2'b11), .OVERLAP(1), .CNT_W(2)) u_c (
    .clk(clk), .rst_n(rst_n), .en(en), .x(x), .clr(clr),
    .state(c_state), .match(c_match), .match_cnt(c_cnt), .cnt_sat(c_sat));

  typedef struct {
    int st;
    int m;
    int cnt;
    int sat;
  } exp_t;

  exp_t  qa[$], qb[$], qc[$];
  int    checks = 0;
  int    errors = 0;
  string tag    = "reset";
  int    step_no = 0;

  function automatic exp_t mk(input int st, input int m, input int cnt, input int sat);
    exp_t e;
    e.st = st; e.m = m; e.cnt = cnt; e.sat = sat;
    return e;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input int exp);
    checks++;
    if (act !== 32'(exp)) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk4(input string dut, input logic [31:0] st, input logic [31:0] m,
                      input logic [31:0] cnt, input logic [31:0] sat, input exp_t e);
    cmp($sformatf("%s/%s#%0d state", tag, dut, step_no), st, e.st);
    cmp($sformatf("%s/%s#%0d match", tag, dut, step_no), m, e.m);
    cmp($sformatf("%s/%s#%0d cnt", tag, dut, step_no), cnt, e.cnt);
    cmp($sformatf("%s/%s#%0d sat", tag, dut, step_no), sat, e.sat);
  endtask

  // Monitor: every queued expectation belongs to the edge that follows it.
  exp_t ea, eb, ec;
  always @(posedge clk) begin
    #1;
    if (qa.size() > 0) begin
      ea = qa.pop_front();
      chk4("a", 32'(a_state), 32'(a_match), 32'(a_cnt), 32'(a_sat), ea);
    end
    if (qb.size() > 0) begin
      eb = qb.pop_front();
      chk4("b", 32'(b_state), 32'(b_match), 32'(b_cnt), 32'(b_sat), eb);
    end
    if (qc.size() > 0) begin
      ec = qc.pop_front();
      chk4("c", 32'(c_state), 32'(c_match), 32'(c_cnt), 32'(c_sat), ec);
    end
  end

  // mask bit0 = a, bit1 = b, bit2 = c
  task automatic step(input logic e, input logic b, input logic c, input int mask,
                      input exp_t xa, input exp_t xb, input exp_t xc);
    @(negedge clk);
    en  = e;
    x   = b;
    clr = c;
    step_no++;
    if (mask[0]) qa.push_back(xa);
    if (mask[1]) qb.push_back(xb);
    if (mask[2]) qc.push_back(xc);
  endtask

  task automatic all_zero(input string what);
    cmp({what, " a state"}, 32'(a_state), 0);
    cmp({what, " a match"}, 32'(a_match), 0);
    cmp({what, " a cnt"},   32'(a_cnt), 0);
    cmp({what, " a sat"},   32'(a_sat), 0);
  endtask

  task automatic do_reset(input string name);
    @(negedge clk);
    rst_n = 1'b0;
    en = 1'b0; x = 1'b0; clr = 1'b0;
    @(negedge clk);
    tag = name;
    step_no = 0;
    all_zero({name, " rst"});
    cmp({name, " rst c sat"}, 32'(c_sat), 0);
    cmp({name, " rst c cnt"}, 32'(c_cnt), 0);
    rst_n = 1'b1;
  endtask

  exp_t z;

  initial begin
    int t1_bits[7] = '{1, 0, 1, 1, 0, 1, 1};
    int t1_ast[7]  = '{1, 2, 3, 1, 2, 3, 1};
    int t1_am[7]   = '{0, 0, 0, 1, 0, 0, 1};
    int t1_ac[7]   = '{0, 0, 0, 1, 1, 1, 2};
    int t1_bst[7]  = '{1, 2, 3, 0, 0, 1, 1};
    int t1_bm[7]   = '{0, 0, 0, 1, 0, 0, 0};
    int t1_bc[7]   = '{0, 0, 0, 1, 1, 1, 1};
    int p4[4]      = '{1, 0, 1, 1};
    z = mk(0, 0, 0, 0);

    // 1 and 2: overlapping vs non-overlapping on the same stream
    do_reset("t1");
    for (int i = 0; i < 7; i++)
      step(1'b1, t1_bits[i][0], 1'b0, 3,
           mk(t1_ast[i], t1_am[i], t1_ac[i], 0),
           mk(t1_bst[i], t1_bm[i], t1_bc[i], 0), z);

    // 3: en gaps with toggled x are ignored
    do_reset("t3");
    for (int i = 0; i < 4; i++) begin
      if (i < 3) begin
        step(1'b1, p4[i][0], 1'b0, 1, mk(i + 1, 0, 0, 0), z, z);
        for (int g = 0; g < 3; g++)
          step(1'b0, ~p4[i][0], 1'b0, 1, mk(i + 1, 0, 0, 0), z, z);
      end else begin
        step(1'b1, p4[i][0], 1'b0, 1, mk(1, 1, 1, 0), z, z);
      end
    end
    step(1'b0, 1'b1, 1'b0, 1, mk(1, 0, 1, 0), z, z);

    // 4: back-to-back matches and counter saturation on instance c
    do_reset("t4");
    for (int i = 0; i < 6; i++)
      step(1'b1, 1'b1, 1'b0, 4, z, z,
           mk(1, (i >= 1) ? 1 : 0, (i < 3) ? i : 3, (i >= 4) ? 1 : 0));
    step(1'b0, 1'b1, 1'b0, 4, z, z, mk(1, 0, 3, 1));

    // 5: synchronous clear beats en
    do_reset("t5");
    for (int i = 0; i < 4; i++)
      step(1'b1, p4[i][0], 1'b0, 1, mk(t1_ast[i], t1_am[i], t1_ac[i], 0), z, z);
    step(1'b1, 1'b1, 1'b0, 1, mk(1, 0, 1, 0), z, z);
    step(1'b1, 1'b0, 1'b0, 1, mk(2, 0, 1, 0), z, z);
    step(1'b1, 1'b1, 1'b0, 1, mk(3, 0, 1, 0), z, z);
    step(1'b1, 1'b1, 1'b1, 1, mk(0, 0, 0, 0), z, z);
    for (int i = 0; i < 4; i++)
      step(1'b1, p4[i][0], 1'b0, 1, mk(t1_ast[i], t1_am[i], t1_ac[i], 0), z, z);

    // 6: asynchronous reset between edges
    do_reset("t6");
    for (int i = 0; i < 6; i++)
      step(1'b1, t1_bits[i][0], 1'b0, 1, mk(t1_ast[i], t1_am[i], t1_ac[i], 0), z, z);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    all_zero("t6 async");
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b1, 1'b0, 1, mk(1, 0, 0, 0), z, z);
    step(1'b1, 1'b1, 1'b0, 1, mk(1, 0, 0, 0), z, z);

    @(negedge clk);
    en = 1'b0;
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
